// File: rtl/perf_counter_csr.sv
`default_nettype none
// ============================================================================
// Module   : perf_counter_csr
// Brief    : Cycle / retired-instruction / branch / mispredict counters with
//            a small CSR read/write port, sticky overflow flags and an IRQ.
// Revision : 1.0 - initial release
// ============================================================================
module perf_counter_csr #(
    parameter int   WIDTH        = 32,
    parameter logic EN_RESET_VAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inst_retire,
    input  logic             br_retire,
    input  logic             br_mispred,
    input  logic [4:0]       csr_addr,
    input  logic             csr_we,
    input  logic             csr_re,
    input  logic [WIDTH-1:0] csr_wdata,
    output logic [WIDTH-1:0] csr_rdata,
    output logic             irq
);

    localparam logic [2:0] A_CTRL    = 3'd0;
    localparam logic [2:0] A_STATUS  = 3'd1;
    localparam logic [2:0] A_CLEAR   = 3'd2;
    localparam logic [2:0] A_CYCLE   = 3'd4;
    localparam logic [2:0] A_INSTR   = 3'd5;
    localparam logic [2:0] A_BRANCH  = 3'd6;
    localparam logic [2:0] A_MISPRED = 3'd7;

    localparam logic [WIDTH-1:0] C_MAX = {WIDTH{1'b1}};

    logic             en_q, en_d;
    logic             irq_en_q, irq_en_d;
    logic [3:0]       status_q, status_d;
    logic [WIDTH-1:0] cyc_q, cyc_d;
    logic [WIDTH-1:0] ins_q, ins_d;
    logic [WIDTH-1:0] brc_q, brc_d;
    logic [WIDTH-1:0] mis_q, mis_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             irq_q, irq_d;

    logic [2:0]       reg_idx;
    logic             wr_ctrl, wr_status, wr_clear;
    logic [3:0]       inc, ovf, w1c_mask;
    logic [WIDTH-1:0] rd_mux;
    logic             unused_bits;

    assign reg_idx   = csr_addr[4:2];
    assign wr_ctrl   = csr_we && (reg_idx == A_CTRL);
    assign wr_status = csr_we && (reg_idx == A_STATUS);
    assign wr_clear  = csr_we && (reg_idx == A_CLEAR);
    assign w1c_mask  = wr_status ? csr_wdata[3:0] : 4'b0000;
    assign unused_bits = ^{csr_addr[1:0], csr_wdata[WIDTH-1:4]};

    // Bit order matches STATUS: {MISPRED, BRANCH, INSTR, CYCLE}
    assign inc = {en_q & br_retire & br_mispred,
                  en_q & br_retire,
                  en_q & inst_retire,
                  en_q};

    assign ovf = inc & {mis_q == C_MAX, brc_q == C_MAX, ins_q == C_MAX, cyc_q == C_MAX};

    // Clear dominates every increment and every overflow in the same cycle
    assign cyc_d = wr_clear ? '0 : cyc_q + {{(WIDTH-1){1'b0}}, inc[0]};
    assign ins_d = wr_clear ? '0 : ins_q + {{(WIDTH-1){1'b0}}, inc[1]};
    assign brc_d = wr_clear ? '0 : brc_q + {{(WIDTH-1){1'b0}}, inc[2]};
    assign mis_d = wr_clear ? '0 : mis_q + {{(WIDTH-1){1'b0}}, inc[3]};

    // A fresh overflow beats a W1C of the same bit
    assign status_d = wr_clear ? 4'b0000 : ((status_q & ~w1c_mask) | ovf);

    assign en_d     = wr_ctrl ? csr_wdata[0] : en_q;
    assign irq_en_d = wr_ctrl ? csr_wdata[1] : irq_en_q;
    assign irq_d    = irq_en_q & (|status_q);

    always_comb begin
        rd_mux = '0;
        case (reg_idx)
            A_CTRL:    rd_mux[1:0] = {irq_en_q, en_q};
            A_STATUS:  rd_mux[3:0] = status_q;
            A_CYCLE:   rd_mux      = cyc_q;
            A_INSTR:   rd_mux      = ins_q;
            A_BRANCH:  rd_mux      = brc_q;
            A_MISPRED: rd_mux      = mis_q;
            default:   rd_mux      = '0;
        endcase
    end

    assign rdata_d = csr_re ? rd_mux : rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q     <= EN_RESET_VAL;
            irq_en_q <= 1'b0;
            status_q <= 4'b0000;
            cyc_q    <= '0;
            ins_q    <= '0;
            brc_q    <= '0;
            mis_q    <= '0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            status_q <= status_d;
            cyc_q    <= cyc_d;
            ins_q    <= ins_d;
            brc_q    <= brc_d;
            mis_q    <= mis_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
        end
    end

    assign csr_rdata = rdata_q;
    assign irq       = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_perf_counter_csr.sv
`default_nettype none
// ============================================================================
// Module   : tb_perf_counter_csr
// Brief    : Directed and randomized checks of perf_counter_csr against a
//            cycle-level behavioural model of the register map.
// Revision : 1.0 - initial release
// ============================================================================
module tb_perf_counter_csr;

    localparam int W = 32;
    localparam longint unsigned MODV = 64'd1 << W;

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic         ir    = 1'b0;
    logic         br    = 1'b0;
    logic         mp    = 1'b0;
    logic         we    = 1'b0;
    logic         re    = 1'b0;
    logic [4:0]   addr  = 5'd0;
    logic [W-1:0] wdata = '0;
    logic [W-1:0] rdata;
    logic         irq;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    longint unsigned m_cnt[4];
    bit [3:0]        m_st;
    bit              m_en, m_ie, m_irq;
    logic [W-1:0]    m_rd;

    always #5 clk = ~clk;

    perf_counter_csr #(.WIDTH(W), .EN_RESET_VAL(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_retire (ir),
        .br_retire   (br),
        .br_mispred  (mp),
        .csr_addr    (addr),
        .csr_we      (we),
        .csr_re      (re),
        .csr_wdata   (wdata),
        .csr_rdata   (rdata),
        .irq         (irq)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%h expected 0x%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_st  = '0;
        m_en  = 1'b1;
        m_ie  = 1'b0;
        m_irq = 1'b0;
        m_rd  = '0;
    endtask

    function automatic logic [W-1:0] model_read(input int idx);
        logic [W-1:0] v;
        v = '0;
        if (idx == 0)      v = W'({m_ie, m_en});
        else if (idx == 1) v = W'(m_st);
        else if (idx >= 4) v = W'(m_cnt[idx-4]);
        return v;
    endfunction

    // One clock edge of the register map, written from the block's rules
    task automatic model_step();
        int           idx;
        logic [W-1:0] rv;
        bit [3:0]     inc, ovf;
        bit           nirq;
        idx    = int'(addr[4:2]);
        rv     = model_read(idx);
        nirq   = m_ie && (m_st != 0);
        inc[0] = m_en;
        inc[1] = m_en && ir;
        inc[2] = m_en && br;
        inc[3] = m_en && br && mp;
        ovf    = '0;
        for (int i = 0; i < 4; i++) begin
            if (inc[i]) begin
                m_cnt[i] = m_cnt[i] + 1;
                if (m_cnt[i] == MODV) begin
                    m_cnt[i] = 0;
                    ovf[i]   = 1'b1;
                end
            end
        end
        if (we && idx == 1) m_st = m_st & ~wdata[3:0];
        m_st = m_st | ovf;
        if (we && idx == 2) begin
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            m_st = '0;
        end
        if (we && idx == 0) begin
            m_en = wdata[0];
            m_ie = wdata[1];
        end
        if (re) m_rd = rv;
        m_irq = nirq;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("rdata", rdata, m_rd);
        check("irq", W'(irq), W'(m_irq));
    endtask

    task automatic rd(input logic [4:0] a);
        addr = a;
        re   = 1'b1;
        tick();
        re   = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [W-1:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    // Back-door load of a counter, applied between edges
    task automatic deposit(input int i, input logic [W-1:0] v);
        case (i)
            0:       dut.cyc_q <= v;
            1:       dut.ins_q <= v;
            2:       dut.brc_q <= v;
            default: dut.mis_q <= v;
        endcase
        m_cnt[i] = v;
    endtask

    initial begin
        model_reset();
        #12;
        check("reset_rdata", rdata, '0);
        check("reset_irq", W'(irq), '0);
        check("reset_cycle", dut.cyc_q, '0);
        rst = 1'b1;

        // 100 retired instructions straight out of reset
        ir = 1'b1;
        repeat (100) tick();
        ir = 1'b0;
        rd(5'h10);
        check("cycle_ge_100", W'(rdata >= W'(100)), W'(1));
        rd(5'h14);
        check("instr_100", rdata, W'(100));

        // Disable, retire while disabled, re-enable with an event in the same cycle
        wr(5'h00, '0);
        ir = 1'b1;
        repeat (50) tick();
        ir = 1'b0;
        rd(5'h14);
        check("instr_frozen", rdata, W'(100));
        ir = 1'b1;
        wr(5'h00, W'(1));
        tick();
        ir = 1'b0;
        rd(5'h14);
        check("instr_resume", rdata, W'(101));
        rd(5'h00);
        check("ctrl_en", rdata, W'(1));

        // Branch and mispredict qualification
        wr(5'h08, '0);
        for (int i = 0; i < 10; i++) begin
            br = 1'b1;
            mp = (i < 3);
            tick();
            br = 1'b0;
            mp = 1'b0;
            tick();
        end
        mp = 1'b1;
        tick();
        tick();
        mp = 1'b0;
        rd(5'h18);
        check("branch_10", rdata, W'(10));
        rd(5'h1C);
        check("mispred_3", rdata, W'(3));

        // INSTR wrap, sticky flag, interrupt, then W1C
        wr(5'h08, '0);
        deposit(1, 32'hFFFF_FFFE);
        wr(5'h00, W'(3));
        ir = 1'b1;
        tick();
        tick();
        ir = 1'b0;
        rd(5'h14);
        check("instr_wrap", rdata, '0);
        check("irq_set", W'(irq), W'(1));
        rd(5'h04);
        check("status_instr", rdata, W'(2));
        wr(5'h04, W'(2));
        tick();
        check("irq_clr", W'(irq), '0);
        rd(5'h04);
        check("status_w1c", rdata, '0);

        // Clear racing an event, CLEAR reads zero, first cycle after clear
        ir = 1'b1;
        wr(5'h08, 32'hDEAD_BEEF);
        ir = 1'b0;
        tick();
        rd(5'h10);
        check("cycle_after_clear", rdata, W'(1));
        rd(5'h14);
        check("instr_cleared", rdata, '0);
        rd(5'h08);
        check("clear_reads_0", rdata, '0);

        // W1C racing a fresh overflow of the same bit: the set wins
        deposit(0, 32'hFFFF_FFFF);
        wr(5'h04, W'(1));
        rd(5'h04);
        check("status_set_wins", rdata, W'(1));

        // Randomized traffic with periodic near-wrap deposits
        for (int n = 0; n < 4000; n++) begin
            if (n % 250 == 0) begin
                for (int i = 0; i < 4; i++)
                    deposit(i, 32'hFFFF_FFFF - W'($urandom_range(0, 3)));
            end
            ir    = 1'($urandom);
            br    = 1'($urandom);
            mp    = 1'($urandom);
            re    = 1'($urandom);
            addr  = 5'($urandom);
            wdata = W'($urandom);
            we    = ($urandom_range(0, 19) == 0);
            if (we && addr[4:2] == 3'd2 && $urandom_range(0, 3) != 0) we = 1'b0;
            if (we && addr[4:2] == 3'd0) wdata[0] = ($urandom_range(0, 3) != 0);
            tick();
        end
        ir = 1'b0; br = 1'b0; mp = 1'b0; re = 1'b0; we = 1'b0;

        // Asynchronous reset in the middle of activity with irq high
        deposit(1, 32'hFFFF_FFFF);
        wr(5'h00, W'(3));
        ir = 1'b1;
        tick();
        rd(5'h10);
        tick();
        check("pre_reset_irq", W'(irq), W'(1));
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        check("arst_rdata", rdata, '0);
        check("arst_irq", W'(irq), '0);
        check("arst_cycle", dut.cyc_q, '0);
        check("arst_instr", dut.ins_q, '0);
        check("arst_status", W'(dut.status_q), '0);
        #2;
        rst = 1'b1;
        ir  = 1'b0;
        rd(5'h00);
        check("ctrl_after_reset", rdata, W'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
